// File: rtl/ps2_pkg.sv
// Shared PS/2 frame constants and scan-code type used by the keyboard receiver.
package ps2_pkg;

    localparam int unsigned PS2_FRAME_BITS = 11;

    localparam logic [7:0] BREAK_PREFIX = 8'hF0;
    localparam logic [7:0] EXT_PREFIX   = 8'hE0;

    typedef logic [7:0] scan_code_t;

endpackage

// File: rtl/ps2_rx_fifo.sv
// Synchronous scan-code FIFO with wrap-bit pointers and a combinational head read.
module ps2_rx_fifo
    import ps2_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       push,
    input  scan_code_t push_data,
    input  logic       pop,
    output scan_code_t head,
    output logic       full,
    output logic       empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    scan_code_t      mem [DEPTH];
    logic [AW:0]     wr_ptr;
    logic [AW:0]     rd_ptr;
    logic [AW:0]     ptr_one;

    assign ptr_one = {{AW{1'b0}}, 1'b1};

    // Equal low bits: empty if wrap bits match, full if they differ.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign head  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            mem    <= '{default: '0};
        end else begin
            if (push && !full) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr              <= wr_ptr + ptr_one;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + ptr_one;
            end
        end
    end

endmodule

// File: rtl/ps2_keyboard.sv
// Receive-only PS/2 keyboard: ps2_clk edge detect, 11-bit frame deframing, byte FIFO.
// Define PS2_KBD_FRAME_CHECK_EN to drop frames failing start/stop/parity and flag frame_err.
module ps2_keyboard
    import ps2_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned SYNC_STAGES = 3
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       nextdata_n,
    output scan_code_t data,
    output logic       ready,
    output logic       overflow,
    output logic       frame_err
);

    logic [SYNC_STAGES-1:0]    sync_q;
    logic [3:0]                count_q;
    logic [PS2_FRAME_BITS-2:0] buf_q;

    logic       sample;
    logic       frame_done;
    logic       frame_ok;
    logic       push;
    logic       pop;
    logic       full;
    logic       empty;
    scan_code_t frame_byte;

    // Two oldest stages reading 1 then 0 mark a settled falling edge of ps2_clk.
    assign sample     = sync_q[SYNC_STAGES-1] & ~sync_q[SYNC_STAGES-2];
    assign frame_done = sample && (count_q == 4'(PS2_FRAME_BITS - 1));
    assign frame_byte = buf_q[8:1];

`ifdef PS2_KBD_FRAME_CHECK_EN
    // Stop bit is the live ps2_data on the final strobe; parity is odd over data+parity.
    assign frame_ok = ~buf_q[0] & ps2_data & (^buf_q[9:1]);
`else
    logic unused_frame_bits;
    assign unused_frame_bits = ^{buf_q[0], buf_q[9]};
    assign frame_ok          = 1'b1;
    assign frame_err         = 1'b0;
`endif

    assign push  = frame_done & frame_ok;
    assign ready = ~empty;
    assign pop   = ~nextdata_n & ready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], ps2_clk};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_q  <= '0;
            buf_q    <= '0;
            overflow <= 1'b0;
        end else if (sample) begin
            if (frame_done) begin
                count_q <= '0;
                if (push && full) begin
                    overflow <= 1'b1;
                end
            end else begin
                buf_q[count_q] <= ps2_data;
                count_q        <= count_q + 4'd1;
            end
        end
    end

`ifdef PS2_KBD_FRAME_CHECK_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            frame_err <= 1'b0;
        end else if (frame_done && !frame_ok) begin
            frame_err <= 1'b1;
        end
    end
`endif

    ps2_rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (push),
        .push_data (frame_byte),
        .pop       (pop),
        .head      (data),
        .full      (full),
        .empty     (empty)
    );

endmodule

// File: tb/tb_ps2_keyboard.sv
// Bench for ps2_keyboard: frame-level reference model checked every cycle, plus directed literals.
`timescale 1ns/1ps
module tb_ps2_keyboard;

    localparam int SYNC_STAGES = 3;
    localparam int DEPTH       = 8;
    // A ps2_clk fall first seen at clk edge E is acted on SYNC_STAGES-1 edges later.
    localparam int LAT         = SYNC_STAGES - 1;

    logic       clk        = 1'b0;
    logic       resetn     = 1'b0;
    logic       ps2_clk    = 1'b1;
    logic       ps2_data   = 1'b1;
    logic       nextdata_n = 1'b1;
    logic [7:0] data;
    logic       ready;
    logic       overflow;
    logic       frame_err;

    int n_checks = 0;
    int n_fails  = 0;

    ps2_keyboard #(
        .FIFO_DEPTH  (DEPTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .nextdata_n (nextdata_n),
        .data       (data),
        .ready      (ready),
        .overflow   (overflow),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] mq[$];
    bit         m_ovf    = 1'b0;
    bit         m_ferr   = 1'b0;
    int         fall_age = -1;
    bit         prev_ps2 = 1'b1;
    int         nbits    = 0;
    logic [9:0] fb       = '0;

    initial begin
        forever begin
            @(posedge clk);
            if (!resetn) begin
                mq.delete();
                m_ovf    = 1'b0;
                m_ferr   = 1'b0;
                fall_age = -1;
                prev_ps2 = 1'b1;
                nbits    = 0;
                fb       = '0;
            end else begin
                automatic bit do_pop = !nextdata_n && (mq.size() > 0);
                automatic bit good;
                if (fall_age >= 0) fall_age++;
                if (prev_ps2 && !ps2_clk) fall_age = 0;
                prev_ps2 = ps2_clk;
                if (fall_age == LAT) begin
                    fall_age = -1;
                    if (nbits < 10) begin
                        fb = {ps2_data, fb[9:1]};
                        nbits++;
                    end else begin
                        nbits = 0;
`ifdef PS2_KBD_FRAME_CHECK_EN
                        good = !fb[0] && ps2_data && (^fb[9:1]);
`else
                        good = 1'b1;
`endif
                        if (!good) m_ferr = 1'b1;
                        else if (mq.size() >= DEPTH) m_ovf = 1'b1;
                        else mq.push_back(fb[8:1]);
                    end
                end
                if (do_pop) void'(mq.pop_front());
            end
        end
    end

    // Per-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (resetn) begin
                check("ready", ready, mq.size() > 0);
                if (mq.size() > 0) check("data", data, mq[0]);
                check("overflow", overflow, m_ovf);
                check("frame_err", frame_err, m_ferr);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic send_bits(input logic [7:0] b, input bit bad_start, input bit bad_par,
                             input bit bad_stop, input int half, input int count);
        logic [10:0] f;
        f = {~bad_stop, (~^b) ^ bad_par, b, bad_start};
        for (int i = 0; i < count; i++) begin
            ps2_data = f[i];
            repeat (half) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (half) @(negedge clk);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (half) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b);
        send_bits(b, 1'b0, 1'b0, 1'b0, 8, 11);
    endtask

    task automatic pop1();
        nextdata_n = 1'b0;
        @(negedge clk);
        nextdata_n = 1'b1;
    endtask

    task automatic check_reset_state();
        check("rst_ready", ready, 1'b0);
        check("rst_overflow", overflow, 1'b0);
        check("rst_frame_err", frame_err, 1'b0);
        check("rst_data", data, 8'h00);
    endtask

    bit done    = 1'b0;
    int rd_pct  = 0;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check_reset_state();
        resetn = 1'b1;
        @(negedge clk);

        // Single byte, then one pop empties the FIFO.
        send_frame(8'h1C);
        check("1c_ready", ready, 1'b1);
        check("1c_data", data, 8'h1C);
        pop1();
        check("1c_empty", ready, 1'b0);

        // Two bytes in order.
        send_frame(8'hF0);
        send_frame(8'h1C);
        check("f0_data", data, 8'hF0);
        pop1();
        check("f0_1c_data", data, 8'h1C);
        pop1();
        check("f0_1c_empty", ready, 1'b0);
        check("f0_1c_ovf", overflow, 1'b0);

        // Nine bytes into an 8-deep FIFO: the ninth is dropped.
        for (int i = 1; i <= 9; i++) send_frame(8'(i));
        check("fill_ovf", overflow, 1'b1);
        for (int i = 1; i <= 8; i++) begin
            check("fill_data", data, 32'(i));
            pop1();
        end
        check("fill_empty", ready, 1'b0);

        // Bad parity.
        send_bits(8'h1C, 1'b0, 1'b1, 1'b0, 8, 11);
`ifdef PS2_KBD_FRAME_CHECK_EN
        check("badpar_ready", ready, 1'b0);
        check("badpar_ferr", frame_err, 1'b1);
`else
        check("badpar_ready", ready, 1'b1);
        check("badpar_data", data, 8'h1C);
        check("badpar_ferr", frame_err, 1'b0);
        pop1();
`endif

        // Reset mid-frame discards partial bits.
        send_bits(8'h55, 1'b0, 1'b0, 1'b0, 8, 5);
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_state();
        resetn = 1'b1;
        @(negedge clk);
        send_frame(8'h2A);
        check("post_rst_ready", ready, 1'b1);
        check("post_rst_data", data, 8'h2A);
        check("post_rst_ovf", overflow, 1'b0);
        check("post_rst_ferr", frame_err, 1'b0);
        pop1();

        // Continuous read strobe: each byte leaves right after arriving.
        nextdata_n = 1'b0;
        send_frame(8'h1C);
        check("stream_empty0", ready, 1'b0);
        send_frame(8'h32);
        check("stream_empty1", ready, 1'b0);
        send_frame(8'h21);
        check("stream_empty2", ready, 1'b0);
        check("stream_ovf", overflow, 1'b0);
        nextdata_n = 1'b1;

        // Randomized frames, corruptions, speeds and reader behaviour.
        fork
            begin
                for (int n = 0; n < 48; n++) begin
                    automatic logic [7:0] b   = 8'($urandom);
                    automatic bit         bad = ($urandom_range(0, 5) == 0);
                    automatic int         sel = $urandom_range(0, 2);
                    if (n % 12 == 0) rd_pct = (n % 24 == 0) ? 0 : 30;
                    send_bits(b, bad && sel == 0, bad && sel == 1, bad && sel == 2,
                              $urandom_range(5, 12), 11);
                    repeat ($urandom_range(0, 20)) @(negedge clk);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(negedge clk);
                    nextdata_n = !($urandom_range(0, 99) < rd_pct);
                end
            end
        join
        nextdata_n = 1'b1;

        // Drain what is left.
        for (int i = 0; i < DEPTH + 2; i++) pop1();
        repeat (2) @(negedge clk);
        check("final_empty", ready, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
